// File: rtl/case_6_sdiv_22s_10s_22_seq.sv
// Sequential signed divider: 22-bit dividend / 10-bit divisor, radix-2 restoring,
// fixed 23-cycle latency from the accepting edge to the registered result with done.
//
// state  | meaning
// S_IDLE | waiting for start; outputs hold the last result
// S_CALC | one quotient bit per cycle, MSB first, 22 iterations
// S_FIX  | apply signs / special cases, register results, pulse done
module case_6_sdiv_22s_10s_22_seq #(
   parameter int din0_WIDTH = 22,
   parameter int din1_WIDTH = 10,
   parameter int dout_WIDTH = 22
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  busy,
   output logic                  done,
   output logic [dout_WIDTH-1:0] dout,
   output logic [din1_WIDTH-1:0] rem,
   output logic                  div0,
   output logic                  ovf
);

   localparam int W0 = din0_WIDTH;
   localparam int W1 = din1_WIDTH;
   localparam int CW = $clog2(W0);
   localparam logic [W0-1:0] MIN0 = {1'b1, {(W0-1){1'b0}}};
   localparam logic [W0-1:0] MAX0 = {1'b0, {(W0-1){1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t          state_q, state_d;
   logic [W0-1:0]   a_q, a_d;
   logic [W1-1:0]   b_q, b_d;
   logic [W1:0]     pr_q, pr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic            div0_pend_q, div0_pend_d;
   logic            ovf_pend_q, ovf_pend_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [W0-1:0]   dout_q, dout_d;
   logic [W1-1:0]   rem_q, rem_d;
   logic            div0_q, div0_d;
   logic            ovf_q, ovf_d;

   logic [W1+1:0]   pr_sh;
   logic [W1+1:0]   trial;

   // a_q carries the dividend magnitude in and the quotient out as it shifts
   always_comb begin
      pr_sh       = {pr_q, a_q[W0-1]};
      trial       = pr_sh - {2'b00, b_q};
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      pr_d        = pr_q;
      cnt_d       = cnt_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      div0_pend_d = div0_pend_q;
      ovf_pend_d  = ovf_pend_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      dout_d      = dout_q;
      rem_d       = rem_q;
      div0_d      = div0_q;
      ovf_d       = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d         = din0[W0-1] ? -din0 : din0;
               b_d         = din1[W1-1] ? -din1 : din1;
               qneg_d      = din0[W0-1] ^ din1[W1-1];
               rneg_d      = din0[W0-1];
               div0_pend_d = (din1 == '0);
               ovf_pend_d  = (din0 == MIN0) && (din1 == '1);
               pr_d        = '0;
               cnt_d       = '0;
               busy_d      = 1'b1;
               state_d     = S_CALC;
            end
         end
         S_CALC: begin
            if (!trial[W1+1]) begin
               pr_d = trial[W1:0];
               a_d  = {a_q[W0-2:0], 1'b1};
            end else begin
               pr_d = pr_sh[W1:0];
               a_d  = {a_q[W0-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W0 - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            div0_d  = div0_pend_q;
            ovf_d   = ovf_pend_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (div0_pend_q) begin
               dout_d = rneg_q ? MIN0 : MAX0;
               rem_d  = '0;
            end else if (ovf_pend_q) begin
               dout_d = MIN0;
               rem_d  = '0;
            end else begin
               dout_d = qneg_q ? -a_q : a_q;
               rem_d  = rneg_q ? -pr_q[W1-1:0] : pr_q[W1-1:0];
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         pr_q        <= '0;
         cnt_q       <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         div0_pend_q <= 1'b0;
         ovf_pend_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dout_q      <= '0;
         rem_q       <= '0;
         div0_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         pr_q        <= pr_d;
         cnt_q       <= cnt_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         div0_pend_q <= div0_pend_d;
         ovf_pend_q  <= ovf_pend_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         dout_q      <= dout_d;
         rem_q       <= rem_d;
         div0_q      <= div0_d;
         ovf_q       <= ovf_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign dout = dout_q;
   assign rem  = rem_q;
   assign div0 = div0_q;
   assign ovf  = ovf_q;

endmodule
